div_unit: RTL and testbench

Parametrised iterative divider for the yangmips execute stage. It replaces single-cycle arithmetic for DIV/DIVU with a restoring radix-2 engine, which takes one quotient bit per cycle. EX raises stallreq_from_ex while busy_o is high. EX/MEM writes {remainder, quotient} into HI/LO when ready_o is high. Width, signed mode, annul (flush) and divide-by-zero reporting are new relative to the existing multi-cycle MADD/MSUB path.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 18 +
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and opcodes for the iterative divider used by the execute stage.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        END
    } div_state_t;

    // EX decodes these aluops into start_i / signed_i.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract, then keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             quot_bit
);

    logic [WIDTH:0] trial;

    // partial_rem < 2*divisor, so a borrow always lands in the MSB of the WIDTH+1 bit difference.
    assign trial    = partial_rem - {1'b0, divisor};
    assign quot_bit = ~trial[WIDTH];
    assign next_rem = trial[WIDTH] ? partial_rem[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, result held until released.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic [2*WIDTH-1:0] result_o
);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] rem;
    logic             neg_quot;
    logic             neg_rem;

    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic             cnt_done;

    assign op1_neg  = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg  = signed_i & opdata2_i[WIDTH-1];
    assign op1_mag  = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag  = op2_neg ? -opdata2_i : opdata2_i;
    assign cnt_done = (cnt == CNT_W'(WIDTH));
    assign quot_fix = neg_quot ? -dividend : dividend;
    assign rem_fix  = neg_rem ? -rem : rem;
    assign busy_o   = (state != IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem ({rem, dividend[WIDTH-1]}),
        .divisor     (divisor),
        .next_rem    (step_rem),
        .quot_bit    (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets its default first so no branch leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_i && !annul_i)
                         state_next = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_next = annul_i ? IDLE : END;
            ON:      if (annul_i)       state_next = IDLE;
                     else if (cnt_done) state_next = END;
            END:     if (annul_i || !start_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            divisor    <= '0;
            dividend   <= '0;
            rem        <= '0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
            result_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        divisor  <= op2_mag;
                        dividend <= op1_mag;
                        rem      <= '0;
                        cnt      <= '0;
                        neg_quot <= op1_neg ^ op2_neg;
                        neg_rem  <= op1_neg;
                    end
                end
                BYZERO: begin
                    if (!annul_i) begin
                        result_o   <= '0;
                        div_zero_o <= 1'b1;
                        ready_o    <= 1'b1;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        if (cnt_done) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                        end else begin
                            rem      <= step_rem;
                            dividend <= {dividend[WIDTH-2:0], step_q};
                            cnt      <= cnt + CNT_W'(1);
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        ready_o    <= 1'b0;
                        div_zero_o <= 1'b0;
                        result_o   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a 32-bit and an 8-bit instance checked against native division.
module tb_div_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8, sgn, annul;
    logic [31:0] op1, op2;

    logic        busy32, ready32, dz32;
    logic [63:0] res32;
    logic        busy8, ready8, dz8;
    logic [15:0] res8;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .signed_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
        .busy_o(busy32), .ready_o(ready32), .div_zero_o(dz32), .result_o(res32)
    );

    div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .signed_i(sgn),
        .opdata1_i(op1[7:0]), .opdata2_i(op2[7:0]), .annul_i(annul),
        .busy_o(busy8), .ready_o(ready8), .div_zero_o(dz8), .result_o(res8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result from native signed/unsigned division on 64-bit integers.
    function automatic exp_t model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint m, sa, sb, q, r;
        m  = (longint'(1) << w) - 1;
        sa = longint'({32'b0, a}) & m;
        sb = longint'({32'b0, b}) & m;
        if (s && sa[w-1]) sa = sa - (longint'(1) << w);
        if (s && sb[w-1]) sb = sb - (longint'(1) << w);
        if (sb == 0) begin
            e.q = '0; e.r = '0; e.dz = 1'b1; e.lat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.q = 32'(q & m); e.r = 32'(r & m); e.dz = 1'b0; e.lat = w + 1;
        end
        return e;
    endfunction

    function automatic logic o_busy(input bit w8);  return w8 ? busy8  : busy32;  endfunction
    function automatic logic o_ready(input bit w8); return w8 ? ready8 : ready32; endfunction
    function automatic logic o_dz(input bit w8);    return w8 ? dz8    : dz32;    endfunction
    function automatic logic [31:0] o_q(input bit w8);
        return w8 ? {24'b0, res8[7:0]} : res32[31:0];
    endfunction
    function automatic logic [31:0] o_r(input bit w8);
        return w8 ? {24'b0, res8[15:8]} : res32[63:32];
    endfunction
    function automatic logic [63:0] o_res(input bit w8);
        return w8 ? {48'b0, res8} : res32;
    endfunction

    task automatic set_start(input bit w8, input logic v);
        if (w8) start8 = v;
        else    start32 = v;
    endtask

    // One full transaction: start held until ready, one extra held cycle, then release.
    task automatic run_div(input string tag, input bit w8, input bit s,
                           input logic [31:0] a, input logic [31:0] b, input bit end_annul);
        exp_t e;
        int   n;
        sb_q.push_back(model(w8 ? 8 : 32, s, a, b));
        @(negedge clk);
        sgn = s; op1 = a; op2 = b;
        set_start(w8, 1'b1);
        @(negedge clk);
        check($sformatf("%s.busy", tag), 64'(o_busy(w8)), 64'd1);
        n = 1;
        while (!o_ready(w8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        check($sformatf("%s.latency", tag), 64'(n - 1), 64'(e.lat));
        check($sformatf("%s.quot", tag), 64'(o_q(w8)), 64'(e.q));
        check($sformatf("%s.rem", tag), 64'(o_r(w8)), 64'(e.r));
        check($sformatf("%s.div_zero", tag), 64'(o_dz(w8)), 64'(e.dz));
        @(negedge clk);
        check($sformatf("%s.held_ready", tag), 64'(o_ready(w8)), 64'd1);
        check($sformatf("%s.held_quot", tag), 64'(o_q(w8)), 64'(e.q));
        if (end_annul) annul = 1'b1;
        else           set_start(w8, 1'b0);
        @(negedge clk);
        set_start(w8, 1'b0);
        annul = 1'b0;
        check($sformatf("%s.idle_busy", tag), 64'(o_busy(w8)), 64'd0);
        check($sformatf("%s.idle_ready", tag), 64'(o_ready(w8)), 64'd0);
        check($sformatf("%s.idle_result", tag), o_res(w8), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ready;
        rst = 1'b0; start32 = 1'b0; start8 = 1'b0; sgn = 1'b0; annul = 1'b0;
        op1 = '0; op2 = '0;
        #12;
        check("reset.busy", 64'(busy32), 64'd0);
        check("reset.ready", 64'(ready32), 64'd0);
        check("reset.div_zero", 64'(dz32), 64'd0);
        check("reset.result", res32, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u7_2", 1'b0, 1'b0, 32'd7, 32'd2, 1'b0);
        run_div("s-7_2", 1'b0, 1'b1, -32'sd7, 32'd2, 1'b0);
        run_div("s7_-2", 1'b0, 1'b1, 32'd7, -32'sd2, 1'b0);
        run_div("u_div0", 1'b0, 1'b0, 32'd5, 32'd0, 1'b0);
        run_div("s_div0", 1'b0, 1'b1, -32'sd5, 32'd0, 1'b0);
        run_div("s_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("u_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div("u_big", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_div("annul_end", 1'b0, 1'b0, 32'd9, 32'd3, 1'b1);
        for (int i = 0; i < 4; i++)
            run_div($sformatf("rand%0d", i), 1'b0, 1'(i[0]), $urandom, $urandom_range(1, 32'h00FF_FFFF), 1'b0);

        // Flush in the middle of an iteration run.
        @(negedge clk);
        sgn = 1'b0; op1 = 32'd12345; op2 = 32'd67; start32 = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1; start32 = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("annul.busy", 64'(busy32), 64'd0);
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready32) saw_ready = 1'b1;
        end
        check("annul.no_ready", 64'(saw_ready), 64'd0);
        run_div("u100_7", 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);

        // Annul wins over start in IDLE.
        @(negedge clk);
        op1 = 32'd50; op2 = 32'd3; start32 = 1'b1; annul = 1'b1;
        @(negedge clk);
        check("annul_start.busy", 64'(busy32), 64'd0);
        start32 = 1'b0; annul = 1'b0;

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; start32 = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b0; start32 = 1'b0;
        #1;
        check("rst_mid.busy", 64'(busy32), 64'd0);
        check("rst_mid.ready", 64'(ready32), 64'd0);
        check("rst_mid.div_zero", 64'(dz32), 64'd0);
        check("rst_mid.result", res32, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready32 || busy32) saw_ready = 1'b1;
        end
        check("rst_mid.stays_idle", 64'(saw_ready), 64'd0);

        run_div("w8_u200_13", 1'b1, 1'b0, 32'd200, 32'd13, 1'b0);
        run_div("w8_s_ovf", 1'b1, 1'b1, 32'h80, 32'hFF, 1'b0);
        run_div("w8_s-100_7", 1'b1, 1'b1, 32'h9C, 32'd7, 1'b0);
        run_div("w8_div0", 1'b1, 1'b0, 32'd9, 32'd0, 1'b0);

        check("scoreboard.empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
